// File: rtl/jtag_tap_responder.sv
// JTAG TAP slave running entirely on the system clock: host pins are oversampled,
// TCK edges become single-cycle strobes, and the 1149.1 TAP drives IDCODE/user/bypass DRs.
`timescale 1ns/1ps
module jtag_tap_responder #(
    parameter logic [31:0] IDCODE  = 32'h1000_0001,
    parameter logic [4:0]  USER_IR = 5'h10
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        jtag_TCK,
    input  logic        jtag_TMS,
    input  logic        jtag_TDI,
    input  logic        jtag_TRSTn,
    output logic        jtag_TDO_data,
    output logic        jtag_TDO_driven,
    input  logic [31:0] user_capture_data,
    output logic        user_update_valid,
    output logic [31:0] user_update_data,
    output logic [3:0]  tap_state
);

    localparam int unsigned IR_W   = 5;
    localparam int unsigned DR_W   = 32;
    localparam int unsigned SYNC_W = 2;

    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(5'h01);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(5'b00001);

    typedef enum logic [3:0] {
        TAP_TLR     = 4'd0,
        TAP_RTI     = 4'd1,
        TAP_SEL_DR  = 4'd2,
        TAP_CAP_DR  = 4'd3,
        TAP_SH_DR   = 4'd4,
        TAP_EX1_DR  = 4'd5,
        TAP_PAU_DR  = 4'd6,
        TAP_EX2_DR  = 4'd7,
        TAP_UPD_DR  = 4'd8,
        TAP_SEL_IR  = 4'd9,
        TAP_CAP_IR  = 4'd10,
        TAP_SH_IR   = 4'd11,
        TAP_EX1_IR  = 4'd12,
        TAP_PAU_IR  = 4'd13,
        TAP_EX2_IR  = 4'd14,
        TAP_UPD_IR  = 4'd15
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_IDCODE = 2'd0,
        DR_USER   = 2'd1,
        DR_BYPASS = 2'd2
    } dr_sel_e;

    logic [SYNC_W-1:0] tck_sync_q;
    logic              tck_dly_q;
    logic [SYNC_W-1:0] tms_sync_q;
    logic [SYNC_W-1:0] tdi_sync_q;
    logic [SYNC_W-1:0] trst_sync_q;

    logic tck_rise_c;
    logic tck_fall_c;
    logic tms_c;
    logic tdi_c;
    logic trst_n_c;

    tap_state_e       state_q, state_d;
    tap_state_e       tap_next_c;
    dr_sel_e          dr_sel_c;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic [IR_W-1:0]  ir_shift_q, ir_shift_d;
    logic [DR_W-1:0]  dr_shift_q, dr_shift_d;
    logic             tdo_data_q, tdo_data_d;
    logic             tdo_driven_q, tdo_driven_d;
    logic             upd_valid_q, upd_valid_d;
    logic [DR_W-1:0]  upd_data_q, upd_data_d;

    // Two-flop synchronizers; TCK gets a third flop so edges can be detected.
    // Reset values mirror idle pins so releasing reset never fakes a TCK edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tck_sync_q  <= '0;
            tck_dly_q   <= 1'b0;
            tms_sync_q  <= '1;
            tdi_sync_q  <= '0;
            trst_sync_q <= '1;
        end else begin
            tck_sync_q  <= {tck_sync_q[0], jtag_TCK};
            tck_dly_q   <= tck_sync_q[SYNC_W-1];
            tms_sync_q  <= {tms_sync_q[0], jtag_TMS};
            tdi_sync_q  <= {tdi_sync_q[0], jtag_TDI};
            trst_sync_q <= {trst_sync_q[0], jtag_TRSTn};
        end
    end

    assign tck_rise_c = tck_sync_q[SYNC_W-1] & ~tck_dly_q;
    assign tck_fall_c = ~tck_sync_q[SYNC_W-1] & tck_dly_q;
    assign tms_c      = tms_sync_q[SYNC_W-1];
    assign tdi_c      = tdi_sync_q[SYNC_W-1];
    assign trst_n_c   = trst_sync_q[SYNC_W-1];

    // Standard 1149.1 transition table, evaluated against the synchronized TMS.
    always_comb begin : tap_next_state
        tap_next_c = state_q;
        case (state_q)
            TAP_TLR:    tap_next_c = tms_c ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    tap_next_c = tms_c ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: tap_next_c = tms_c ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: tap_next_c = tms_c ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  tap_next_c = tms_c ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: tap_next_c = tms_c ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: tap_next_c = tms_c ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: tap_next_c = tms_c ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: tap_next_c = tms_c ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: tap_next_c = tms_c ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: tap_next_c = tms_c ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  tap_next_c = tms_c ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: tap_next_c = tms_c ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: tap_next_c = tms_c ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: tap_next_c = tms_c ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: tap_next_c = tms_c ? TAP_SEL_DR : TAP_RTI;
            default:    tap_next_c = TAP_TLR;
        endcase
    end

    // IDCODE takes priority so a USER_IR equal to the IDCODE opcode cannot shadow it.
    always_comb begin : dr_select
        dr_sel_c = DR_BYPASS;
        if (ir_q == IR_IDCODE) begin
            dr_sel_c = DR_IDCODE;
        end else if (ir_q == USER_IR) begin
            dr_sel_c = DR_USER;
        end
    end

    // All TAP actions happen on the rise strobe, TDO moves on the fall strobe;
    // a synchronized TRST overrides both and suppresses any update.
    always_comb begin : tap_datapath
        state_d      = state_q;
        ir_d         = ir_q;
        ir_shift_d   = ir_shift_q;
        dr_shift_d   = dr_shift_q;
        tdo_data_d   = tdo_data_q;
        tdo_driven_d = tdo_driven_q;
        upd_valid_d  = 1'b0;
        upd_data_d   = upd_data_q;

        if (!trst_n_c) begin
            state_d      = TAP_TLR;
            ir_d         = IR_IDCODE;
            tdo_driven_d = 1'b0;
        end else if (tck_rise_c) begin
            state_d = tap_next_c;
            case (state_q)
                TAP_CAP_IR: ir_shift_d = IR_CAPTURE;
                TAP_SH_IR:  ir_shift_d = {tdi_c, ir_shift_q[IR_W-1:1]};
                TAP_CAP_DR: begin
                    case (dr_sel_c)
                        DR_IDCODE: dr_shift_d = IDCODE | DR_W'(1);
                        DR_USER:   dr_shift_d = user_capture_data;
                        default:   dr_shift_d = '0;
                    endcase
                end
                TAP_SH_DR: begin
                    if (dr_sel_c == DR_BYPASS) begin
                        dr_shift_d[0] = tdi_c;
                    end else begin
                        dr_shift_d = {tdi_c, dr_shift_q[DR_W-1:1]};
                    end
                end
                default: ;
            endcase

            if (tap_next_c == TAP_UPD_IR) begin
                ir_d = ir_shift_q;
            end
            if ((tap_next_c == TAP_UPD_DR) && (dr_sel_c == DR_USER)) begin
                upd_valid_d = 1'b1;
                upd_data_d  = dr_shift_q;
            end
            if (tap_next_c == TAP_TLR) begin
                ir_d = IR_IDCODE;
            end
        end else if (tck_fall_c) begin
            tdo_data_d   = (state_q == TAP_SH_IR) ? ir_shift_q[0] : dr_shift_q[0];
            tdo_driven_d = (state_q == TAP_SH_IR) || (state_q == TAP_SH_DR);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= TAP_TLR;
            ir_q         <= IR_IDCODE;
            ir_shift_q   <= '0;
            dr_shift_q   <= '0;
            tdo_data_q   <= 1'b0;
            tdo_driven_q <= 1'b0;
            upd_valid_q  <= 1'b0;
            upd_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            ir_shift_q   <= ir_shift_d;
            dr_shift_q   <= dr_shift_d;
            tdo_data_q   <= tdo_data_d;
            tdo_driven_q <= tdo_driven_d;
            upd_valid_q  <= upd_valid_d;
            upd_data_q   <= upd_data_d;
        end
    end

    assign tap_state         = state_q;
    assign jtag_TDO_data     = tdo_data_q;
    assign jtag_TDO_driven   = tdo_driven_q;
    assign user_update_valid = upd_valid_q;
    assign user_update_data  = upd_data_q;

endmodule

// File: doc/jtag_tap_responder.md
JTAG_TAP_RESPONDER -- requirements
Module: jtag_tap_responder

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1000_0001, meaning the value loaded into the ID register in Capture-DR; bit 0 is always 1.
REQ-002 SHALL have parameter USER_IR, default 5'h10, meaning the instruction selecting the 32-bit user data register.
REQ-003 SHALL have port clock, input, 1 bit, meaning the system clock; all flops use its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports jtag_TCK, jtag_TMS, jtag_TDI and jtag_TRSTn, each input, 1 bit, meaning asynchronous JTAG pins from the host.
REQ-006 SHALL have port jtag_TDO_data, output, 1 bit, meaning the serial data returned to the host.
REQ-007 SHALL have port jtag_TDO_driven, output, 1 bit, meaning TDO is valid; high only in Shift-IR or Shift-DR.
REQ-008 SHALL have port user_capture_data, input, 32 bits, meaning the value loaded into the user DR at Capture-DR.
REQ-009 SHALL have port user_update_valid, output, 1 bit, meaning a one-clock pulse on Update-DR while IR==USER_IR.
REQ-010 SHALL have port user_update_data, output, 32 bits, meaning the last user DR value shifted in; held between updates.
REQ-011 SHALL have port tap_state, output, 4 bits, meaning the current TAP state.

Function
REQ-012 SHALL pass TCK, TMS, TDI and TRSTn through 2-flop synchronizers; TCK SHALL also pass through one extra flop for edge detection; tck_rise and tck_fall are single-cycle strobes.
REQ-013 SHALL sample the synchronized TMS/TDI and perform all state, shift, capture and update actions only on the tck_rise cycle; a host TCK edge is acted upon 3 clocks after the pin changes.
REQ-014 SHALL implement the 16-state IEEE 1149.1 TAP FSM with encoding 0..15: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
REQ-015 SHALL use the standard transitions; in particular, TMS=1 for 5 consecutive tck_rise strobes SHALL reach TLR from any state.
REQ-016 In TLR, IR SHALL be 5'h01 (IDCODE).
REQ-017 CapIR SHALL load the 5-bit IR shift register with 5'b00001.
REQ-018 ShIR and ShDR SHALL shift right with TDI into the MSB of the selected register.
REQ-019 UpdIR SHALL copy the IR shift register to IR.
REQ-020 DR selection SHALL be: IR==5'h01 selects IDCODE (32 bits); IR==USER_IR selects the user DR (32 bits); all other values, including 5'h1F, select BYPASS (1 bit).
REQ-021 CapDR SHALL load IDCODE, user_capture_data, or 0 according to the selected DR.
REQ-022 UpdDR with the user DR selected SHALL load user_update_data from the shift register and pulse user_update_valid for exactly one clock, on the cycle after the UpdDR entry strobe.
REQ-023 On tck_fall, jtag_TDO_data SHALL take the LSB of the active shift register, and jtag_TDO_driven SHALL be 1 in ShIR/ShDR and 0 otherwise.
REQ-024 A tck_rise and a tck_fall SHALL never occur in the same cycle; TCK glitches shorter than 1 clock are not supported.
REQ-025 Synchronized TRSTn low SHALL force TLR and IR=5'h01 on the next clock, overriding any TCK activity, including mid-shift; user_update_data SHALL be unchanged and user_update_valid SHALL not pulse.
REQ-026 Pausing TCK in PauseDR/PauseIR or in any Shift state SHALL hold all register contents indefinitely.

Reset
REQ-027 resetn low SHALL asynchronously set: tap_state=TLR (0), IR=5'h01, all shift registers to 0, jtag_TDO_data=0, jtag_TDO_driven=0, user_update_valid=0, user_update_data=0, synchronizer flops to TCK=0, TMS=1, TRSTn=1.
REQ-028 Release of resetn SHALL take effect at the first clock edge after deassertion, with no spurious tck_rise generated.

Verification
REQ-029 From RTI, 5 TCK cycles with TMS=1 -> tap_state=0 and IR=5'h01.
REQ-030 Reset, then navigate to ShDR and shift 32 bits -> TDO sequence equals 32'h1000_0001, LSB first, with jtag_TDO_driven=1 throughout.
REQ-031 Load IR=5'h10 and shift 32'hDEADBEEF in with user_capture_data=32'h12345678 -> TDO returns 32'h12345678, user_update_data=32'hDEADBEEF, and user_update_valid pulses once.
REQ-032 Load IR=5'h1F and shift pattern 1011 -> TDO returns 0,1,0,1 (bypass adds 1 bit of delay).
REQ-033 Pulse jtag_TRSTn low for 4 clocks mid-ShDR -> tap_state=0 within 3 clocks, IR=5'h01, and no update pulse.
REQ-034 Assert resetn mid-ShIR -> all outputs take their REQ-027 values immediately, without waiting for a clock edge.
